// File: rtl/comb_agc_sequencer.sv
// AGC loop sequencer: runs IDLE -> ACQ -> TRACK from the windowed error of two channels, timing out acquisition.
// Registered state, flags and pulses; the gain outputs are selected by the registered state.
module comb_agc_sequencer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clkEn,
    input  logic               enable,
    input  logic [11:0]        signalLevel0,
    input  logic [11:0]        signalLevel1,
    input  logic [7:0]         agcSetpoint,
    input  logic [4:0]         acqPosGain,
    input  logic [4:0]         acqNegGain,
    input  logic [4:0]         trkPosGain,
    input  logic [4:0]         trkNegGain,
    input  logic [DWELL_W-1:0] acqDwell,
    input  logic [11:0]        lockThreshold,
    input  logic [7:0]         lockCount,
    output logic [4:0]         posErrorGain,
    output logic [4:0]         negErrorGain,
    output logic               zeroError,
    output logic [1:0]         state,
    output logic               locked,
    output logic               acqTimeout,
    output logic               lockLost
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t             cur_state, nxt_state;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         run_q, run_d, run_sat, lock_m1;
    logic               zero_d, locked_d, timeout_d, lost_d;
    logic signed [12:0] err0, err1;
    logic [12:0]        mag0, mag1, thr, thr2;
    logic               in_win, out_win;

    // Both error terms are computed at 13 bits so the full 12-bit range survives the subtraction.
    assign err0    = $signed({1'b0, signalLevel0}) - $signed({1'b0, agcSetpoint, 4'b0000});
    assign err1    = $signed({1'b0, signalLevel1}) - $signed({1'b0, agcSetpoint, 4'b0000});
    assign mag0    = err0[12] ? 13'(-err0) : 13'(err0);
    assign mag1    = err1[12] ? 13'(-err1) : 13'(err1);
    assign thr     = {1'b0, lockThreshold};
    assign thr2    = {lockThreshold, 1'b0};
    assign in_win  = (mag0 <= thr) && (mag1 <= thr);
    assign out_win = (mag0 > thr2) || (mag1 > thr2);
    assign lock_m1 = (lockCount == 8'd0) ? 8'd0 : lockCount - 8'd1;
    assign run_sat = (run_q == 8'hFF) ? run_q : run_q + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state  <= S_IDLE;
            dwell_q    <= '0;
            run_q      <= '0;
            zeroError  <= 1'b1;
            locked     <= 1'b0;
            acqTimeout <= 1'b0;
            lockLost   <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            dwell_q    <= dwell_d;
            run_q      <= run_d;
            zeroError  <= zero_d;
            locked     <= locked_d;
            acqTimeout <= timeout_d;
            lockLost   <= lost_d;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        dwell_d   = dwell_q;
        run_d     = run_q;
        timeout_d = 1'b0;
        lost_d    = 1'b0;
        if (!enable) begin
            nxt_state = S_IDLE;
            dwell_d   = '0;
            run_d     = '0;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    nxt_state = S_ACQ;
                    dwell_d   = acqDwell;
                    run_d     = '0;
                end
                S_ACQ: if (clkEn) begin
                    if (in_win && run_q == lock_m1) begin
                        nxt_state = S_TRACK;
                        run_d     = '0;
                    end else begin
                        run_d = in_win ? run_sat : 8'd0;
                        // A zero dwell never counts down, so it never expires.
                        if (dwell_q == DWELL_W'(1)) begin
                            timeout_d = 1'b1;
                            dwell_d   = acqDwell;
                        end else if (dwell_q != '0) begin
                            dwell_d = dwell_q - DWELL_W'(1);
                        end
                    end
                end
                S_TRACK: if (clkEn) begin
                    if (out_win && run_q == lock_m1) begin
                        nxt_state = S_ACQ;
                        run_d     = '0;
                        dwell_d   = acqDwell;
                        lost_d    = 1'b1;
                    end else begin
                        run_d = out_win ? run_sat : 8'd0;
                    end
                end
                default: nxt_state = S_IDLE;
            endcase
        end
        zero_d   = (nxt_state == S_IDLE);
        locked_d = (nxt_state == S_TRACK);
    end

    always_comb begin
        state        = cur_state;
        posErrorGain = (cur_state == S_TRACK) ? trkPosGain : acqPosGain;
        negErrorGain = (cur_state == S_TRACK) ? trkNegGain : acqNegGain;
    end

endmodule

// File: doc/comb_agc_sequencer.md
COMB_AGC_SEQUENCER -- requirements
Module: comb_agc_sequencer

Interface
REQ-001 Parameter: DWELL_W, 16, width of acquisition dwell counter.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 clkEn  in  1  sample strobe; the loop filter uses the same strobe.
REQ-005 enable  in  1  sequencer run; low forces IDLE.
REQ-006 signalLevel0, signalLevel1  in  12 each  per-channel detected level.
REQ-007 agcSetpoint  in  8  target level; compared as {agcSetpoint,4'b0}.
REQ-008 acqPosGain, acqNegGain, trkPosGain, trkNegGain  in  5 each  acquire/track shift gains.
REQ-009 acqDwell  in  DWELL_W  acquisition timeout, in clkEn samples.
REQ-010 lockThreshold  in  12  lock window on |error|.
REQ-011 lockCount  in  8  consecutive samples needed to declare lock or loss of lock; 0 is treated as 1.
REQ-012 posErrorGain, negErrorGain  out  5 each  gains driven to the loop filter.
REQ-013 zeroError  out  1  forces the loop filter error to zero.
REQ-014 state  out  2  IDLE=0, ACQ=1, TRACK=2; 3 is unused.
REQ-015 locked  out  1  high while in TRACK.
REQ-016 acqTimeout, lockLost  out  1 each  single-cycle event pulses.

Function
REQ-017 Per channel: err = {1'b0,signalLevel} - {1'b0,agcSetpoint,4'b0}, 13-bit signed; mag = |err|, 13-bit unsigned.
REQ-018 inWin = mag0 <= lockThreshold AND mag1 <= lockThreshold; outWin = mag0 > 2*lockThreshold OR mag1 > 2*lockThreshold; compares use 13-bit width, no truncation.
REQ-019 IDLE: zeroError=1; gains=acq gains; counters cleared.
REQ-020 IDLE -> ACQ on the first clk with enable=1; dwell counter is loaded with acqDwell.
REQ-021 ACQ: zeroError=0; gains=acq gains.
REQ-022 ACQ, on each clkEn: dwell decrements; runCnt increments if inWin, else clears to 0.
REQ-023 ACQ -> TRACK on the clkEn where inWin is true and runCnt == max(lockCount,1)-1; runCnt clears.
REQ-024 ACQ dwell expiry: on the clkEn where dwell==1 and lock is not reached, the block pulses acqTimeout, reloads acqDwell and stays in ACQ.
REQ-025 Lock and expiry on the same clkEn: lock wins; no acqTimeout pulse.
REQ-026 acqDwell=0: no timeout ever fires; dwell holds at 0.
REQ-027 TRACK: zeroError=0; gains=trk gains; locked=1.
REQ-028 TRACK, on each clkEn: runCnt increments if outWin, else clears to 0.
REQ-029 TRACK -> ACQ on the clkEn where outWin is true and runCnt == max(lockCount,1)-1; lockLost pulses; dwell reloads.
REQ-030 enable=0 in any state -> IDLE on the next clk, with priority over all other transitions; any pending pulses are suppressed.
REQ-031 All outputs are registered; gain, zeroError and locked change on the same clk edge as state.
REQ-032 Without clkEn, counters and state hold; the only exception is the enable-driven transitions.
REQ-033 runCnt saturates at 255 and never wraps.

Reset
REQ-034 While reset is asserted: state=IDLE, zeroError=1, posErrorGain=acqPosGain, negErrorGain=acqNegGain, locked=0, acqTimeout=0, lockLost=0, all counters 0.
REQ-035 Reset asserted mid-ACQ or mid-TRACK aborts immediately (asynchronous); the block resumes per REQ-020 after release.

Verification
REQ-036 Acquire: enable=1, setpoint=0x80, both levels=0x800, lockThreshold=0x10, lockCount=4, clkEn every cycle -> ACQ for 4 samples, then TRACK; locked=1; gains switch to trk.
REQ-037 Timeout: level0=0x000 and level1=0x800, acqDwell=10 -> acqTimeout pulses every 10 clkEn samples; state stays ACQ.
REQ-038 Loss: in TRACK, level1 steps to 0x830 (mag 0x30 > 0x20) for 4 samples -> lockLost pulse, state ACQ, locked=0. A 3-sample excursion causes no loss.
REQ-039 Disable: enable drops mid-TRACK -> IDLE next clk, zeroError=1, no pulse.
REQ-040 Boundaries: lockCount=0 locks on the first inWin sample; mag == lockThreshold counts as inWin; mag == 2*lockThreshold is not outWin; lock coinciding with dwell expiry gives TRACK and no acqTimeout.
